// File: rtl/flappy_pkg.sv
// Shared types and sizes for the flappy game blocks.
package flappy_pkg;
  localparam int unsigned ROWS  = 8;
  localparam int unsigned gap_w = 3;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;
endpackage

// File: rtl/pipe_scroller_if.sv
// Gap stream link between the gap generator and the pipe scroller.
interface pipe_scroller_if;
  import flappy_pkg::*;

  logic [gap_w-1:0] gap_height;
  logic [gap_w-1:0] gap_size;
  logic             gap_take;

  modport master (output gap_height, output gap_size, input gap_take);
  modport slave  (input gap_height, input gap_size, output gap_take);
endinterface

// File: rtl/pipe_column_gen.sv
// Turns a {height, size} gap description into one obstacle column (1 = pipe).
module pipe_column_gen
  import flappy_pkg::*;
(
  input  logic [gap_w-1:0] height,
  input  logic [gap_w-1:0] size,
  output logic [ROWS-1:0]  column
);

  logic [gap_w:0]   top_sum;
  logic [gap_w-1:0] top;

  always_comb begin
    top_sum = {1'b0, height} + {1'b0, size};
    // Gap top saturates at the highest row instead of wrapping.
    top     = top_sum[gap_w] ? '1 : top_sum[gap_w-1:0];
    column  = '1;
    for (int r = 0; r < int'(ROWS); r++) begin
      column[r] = ~((r >= int'(height)) && (r <= int'(top)));
    end
  end

endmodule

// File: rtl/pipe_scroller.sv
// Scrolling obstacle grid: spawns pipes from the gap stream, shifts left, scores and collides.
module pipe_scroller
  import flappy_pkg::*;
#(
  parameter int unsigned COLS         = 16,
  parameter int unsigned SCROLL_DIV   = 4,
  parameter int unsigned PIPE_SPACING = 6,
  parameter int unsigned BIRD_COL     = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [gap_w-1:0]     bird_row,
  pipe_scroller_if.slave       gap_bus,
  output logic [COLS*ROWS-1:0] grid,
  output logic                 collision,
  output logic                 score_tick
);

  localparam int unsigned DivW = $clog2(SCROLL_DIV);
  localparam int unsigned SpW  = $clog2(PIPE_SPACING);

  state_t                state_q, state_d;
  logic [DivW-1:0]       div_q;
  logic [SpW-1:0]        sp_q;
  logic [COLS*ROWS-1:0]  grid_q;
  logic                  collision_q;
  logic                  score_q;
  logic                  adv;
  logic                  step;
  logic                  spawn;
  logic [ROWS-1:0]       new_col;
  logic [ROWS-1:0]       bird_col;

  pipe_column_gen u_col_gen (
    .height (gap_bus.gap_height),
    .size   (gap_bus.gap_size),
    .column (new_col)
  );

  assign adv      = (state_q == RUN) && enable && !clear;
  assign step     = adv && (div_q == DivW'(SCROLL_DIV - 1));
  assign spawn    = step && (sp_q == '0);
  assign bird_col = grid_q[BIRD_COL*ROWS +: ROWS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = FLUSH;
    end else begin
      unique case (state_q)
        IDLE:    if (enable) state_d = RUN;
        RUN:     if (!enable) state_d = IDLE;
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    gap_bus.gap_take = spawn;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_q       <= '0;
      sp_q        <= '0;
      grid_q      <= '0;
      collision_q <= 1'b0;
      score_q     <= 1'b0;
    end else if (clear) begin
      div_q       <= '0;
      sp_q        <= '0;
      grid_q      <= '0;
      collision_q <= 1'b0;
      score_q     <= 1'b0;
    end else begin
      // The column about to enter BIRD_COL-1 has just cleared the bird.
      score_q <= step && (|bird_col);
      if (state_q == RUN) begin
        collision_q <= bird_col[bird_row];
      end else if (state_q == FLUSH) begin
        collision_q <= 1'b0;
      end
      if (adv) begin
        div_q <= step ? '0 : div_q + 1'b1;
      end
      if (step) begin
        sp_q   <= spawn ? SpW'(PIPE_SPACING - 1) : sp_q - 1'b1;
        grid_q <= {(spawn ? new_col : {ROWS{1'b0}}), grid_q[COLS*ROWS-1:ROWS]};
      end
    end
  end

  assign grid       = grid_q;
  assign collision  = collision_q;
  assign score_tick = score_q;

endmodule
